// File: rtl/keypad_matrix_loader.sv
// Keypad-driven loader for an S x F signed X matrix plus S-element y vector.
// Optional build macro KEYPAD_SIGN_EN enables the 0xA sign-toggle key.
module keypad_matrix_loader #(
    parameter int unsigned ELEM_WIDTH      = 14,
    parameter int unsigned NUM_SAMPLES     = 3,
    parameter int unsigned NUM_FEATURES    = 2,
    parameter int unsigned MAX_DIGITS      = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic [3:0]                                        key_code_i,
    input  logic                                              key_pressed_i,
    input  logic                                              matrix_ready_i,
    output logic [NUM_SAMPLES*NUM_FEATURES*ELEM_WIDTH-1:0]    x_flat_o,
    output logic [NUM_SAMPLES*ELEM_WIDTH-1:0]                 y_flat_o,
    output logic                                              matrix_valid_o,
    output logic signed [ELEM_WIDTH-1:0]                      entry_value_o,
    output logic [$clog2(NUM_SAMPLES*(NUM_FEATURES+1)+1)-1:0] elem_index_o,
    output logic                                              input_error_o
);

    localparam int unsigned NUM_X     = NUM_SAMPLES * NUM_FEATURES;
    localparam int unsigned NUM_ELEMS = NUM_SAMPLES * (NUM_FEATURES + 1);
    localparam int unsigned IDX_W     = $clog2(NUM_ELEMS + 1);
    localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DIG_W     = $clog2(MAX_DIGITS + 1);
    // Wide enough to hold mag*10+9 before the range check.
    localparam int unsigned ACC_W     = ELEM_WIDTH + 4;

    localparam logic [ACC_W-1:0] MaxMag = (ACC_W'(1) << (ELEM_WIDTH - 1)) - ACC_W'(1);

    localparam logic [3:0] KeyClear = 4'hB;
    localparam logic [3:0] KeyDone  = 4'hD;
    localparam logic [3:0] KeyEnter = 4'hE;

    localparam logic [1:0] StCollect = 2'd0;
    localparam logic [1:0] StHold    = 2'd1;
    localparam logic [1:0] StPresent = 2'd2;

    logic [DB_W-1:0]       db_cnt_q, db_cnt_d, db_run;
    logic [3:0]            db_code_q, db_code_d;
    logic                  armed_q, armed_d;
    logic                  key_fire;

    logic [1:0]            state_q, state_d;
    logic [ELEM_WIDTH-1:0] mag_q, mag_d;
    logic [DIG_W-1:0]      dig_q, dig_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic [ELEM_WIDTH-1:0] slot_q [NUM_ELEMS];
    logic [ELEM_WIDTH-1:0] slot_d [NUM_ELEMS];
    logic [ACC_W-1:0]      acc_next;
    logic [ELEM_WIDTH-1:0] entry_val;
    logic                  acc_clr;

    // Debounce: armed keys fire after a stable run; disarmed keys re-arm after a quiet run.
    always_comb begin
        db_cnt_d  = db_cnt_q;
        db_code_d = db_code_q;
        armed_d   = armed_q;
        db_run    = '0;
        key_fire  = 1'b0;
        if (armed_q) begin
            if (key_pressed_i) begin
                if ((db_cnt_q != '0) && (key_code_i == db_code_q)) begin
                    db_run = db_cnt_q + DB_W'(1);
                end else begin
                    db_run = DB_W'(1);
                end
                db_code_d = key_code_i;
                if (db_run == DB_W'(DEBOUNCE_CYCLES)) begin
                    key_fire = 1'b1;
                    armed_d  = 1'b0;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_run;
                end
            end else begin
                db_cnt_d = '0;
            end
        end else begin
            if (!key_pressed_i) begin
                db_run = db_cnt_q + DB_W'(1);
                if (db_run == DB_W'(DEBOUNCE_CYCLES)) begin
                    armed_d  = 1'b1;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_run;
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    assign acc_next = ACC_W'(mag_q) * ACC_W'(10) + ACC_W'(key_code_i);

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        dig_d   = dig_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        err_d   = 1'b0;
        acc_clr = 1'b0;
        case (state_q)
            StCollect: begin
                if (key_fire) begin
                    if (key_code_i <= 4'd9) begin
                        if ((dig_q == DIG_W'(MAX_DIGITS)) || (acc_next > MaxMag)) begin
                            err_d = 1'b1;
                        end else begin
                            mag_d = acc_next[ELEM_WIDTH-1:0];
                            dig_d = dig_q + DIG_W'(1);
                        end
                    end else begin
                        case (key_code_i)
                            KeyClear: acc_clr = 1'b1;
                            KeyEnter: begin
                                slot_d[idx_q] = entry_val;
                                acc_clr       = 1'b1;
                                idx_d         = idx_q + IDX_W'(1);
                                if (idx_q == IDX_W'(NUM_ELEMS - 1)) begin
                                    state_d = StHold;
                                end
                            end
                            KeyDone:  err_d = 1'b1;
                            default:  ;
                        endcase
                    end
                end
            end
            StHold: begin
                if (key_fire) begin
                    if (key_code_i == KeyDone) begin
                        state_d = StPresent;
                    end else if (key_code_i == KeyClear) begin
                        for (int k = 0; k < NUM_ELEMS; k++) begin
                            slot_d[k] = '0;
                        end
                        idx_d   = '0;
                        acc_clr = 1'b1;
                        state_d = StCollect;
                    end
                end
            end
            StPresent: begin
                if (matrix_ready_i) begin
                    state_d = StCollect;
                    idx_d   = '0;
                end
            end
            default: state_d = StCollect;
        endcase
        if (acc_clr) begin
            mag_d = '0;
            dig_d = '0;
        end
    end

`ifdef KEYPAD_SIGN_EN
    localparam logic [3:0] KeySign = 4'hA;

    logic sign_q, sign_d;

    always_comb begin
        sign_d = sign_q;
        if (acc_clr) begin
            sign_d = 1'b0;
        end else if (key_fire && (state_q == StCollect) && (key_code_i == KeySign)) begin
            sign_d = ~sign_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
        end
    end

    // Negating a zero magnitude yields zero, so -0 never reaches a slot.
    assign entry_val = sign_q ? (-mag_q) : mag_q;
`else
    assign entry_val = mag_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt_q  <= '0;
            db_code_q <= '0;
            armed_q   <= 1'b0;
            state_q   <= StCollect;
            mag_q     <= '0;
            dig_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            slot_q    <= '{default: '0};
        end else begin
            db_cnt_q  <= db_cnt_d;
            db_code_q <= db_code_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            mag_q     <= mag_d;
            dig_q     <= dig_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            slot_q    <= slot_d;
        end
    end

    always_comb begin
        x_flat_o = '0;
        y_flat_o = '0;
        for (int k = 0; k < NUM_X; k++) begin
            x_flat_o[k*ELEM_WIDTH +: ELEM_WIDTH] = slot_q[k];
        end
        for (int s = 0; s < NUM_SAMPLES; s++) begin
            y_flat_o[s*ELEM_WIDTH +: ELEM_WIDTH] = slot_q[NUM_X + s];
        end
    end

    assign matrix_valid_o = (state_q == StPresent);
    assign entry_value_o  = entry_val;
    assign elem_index_o   = idx_q;
    assign input_error_o  = err_q;

endmodule

// File: tb/tb_keypad_matrix_loader.sv
// Randomized keypad bench; a key-level reference model feeds a scoreboard
// that an independent monitor drains on input_error and matrix_valid.
module tb_keypad_matrix_loader;

    localparam int W      = 14;
    localparam int S      = 3;
    localparam int F      = 2;
    localparam int MD     = 3;
    localparam int D      = 4;
    localparam int NX     = S * F;
    localparam int NE     = S * (F + 1);
    localparam int XW     = NX * W;
    localparam int YW     = S * W;
    localparam int IW     = $clog2(NE + 1);
    localparam int MAXMAG = (1 << (W - 1)) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [3:0]    key_code;
    logic          key_pressed;
    logic          matrix_ready;
    logic [XW-1:0] x_flat;
    logic [YW-1:0] y_flat;
    logic          matrix_valid;
    logic [W-1:0]  entry_value;
    logic [IW-1:0] elem_index;
    logic          input_error;

    always #5 clock = ~clock;

    keypad_matrix_loader #(
        .ELEM_WIDTH     (W),
        .NUM_SAMPLES    (S),
        .NUM_FEATURES   (F),
        .MAX_DIGITS     (MD),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .key_code_i    (key_code),
        .key_pressed_i (key_pressed),
        .matrix_ready_i(matrix_ready),
        .x_flat_o      (x_flat),
        .y_flat_o      (y_flat),
        .matrix_valid_o(matrix_valid),
        .entry_value_o (entry_value),
        .elem_index_o  (elem_index),
        .input_error_o (input_error)
    );

    typedef struct {
        bit            is_mat;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Key-level reference model: 0 collect, 1 hold, 2 present.
    int   m_state;
    int   m_mag;
    int   m_ndig;
    int   m_idx;
    bit   m_neg;
    int   m_slot[NE];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] to_elem(input int v);
        return W'(v);
    endfunction

    function automatic int model_entry();
        return m_neg ? -m_mag : m_mag;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_mag   = 0;
        m_ndig  = 0;
        m_idx   = 0;
        m_neg   = 1'b0;
        for (int k = 0; k < NE; k++) m_slot[k] = 0;
    endtask

    task automatic model_clear_acc();
        m_mag  = 0;
        m_ndig = 0;
        m_neg  = 1'b0;
    endtask

    task automatic model_key(input int code);
        exp_t e;
        e.is_mat = 1'b0;
        e.x      = '0;
        e.y      = '0;
        if (m_state == 0) begin
            if (code <= 9) begin
                if (m_ndig == MD || m_mag * 10 + code > MAXMAG) exp_q.push_back(e);
                else begin
                    m_mag = m_mag * 10 + code;
                    m_ndig++;
                end
            end else if (code == 10) begin
`ifdef KEYPAD_SIGN_EN
                m_neg = !m_neg;
`endif
            end else if (code == 11) begin
                model_clear_acc();
            end else if (code == 14) begin
                m_slot[m_idx] = model_entry();
                model_clear_acc();
                m_idx++;
                if (m_idx == NE) m_state = 1;
            end else if (code == 13) begin
                exp_q.push_back(e);
            end
        end else if (m_state == 1) begin
            if (code == 13) begin
                m_state  = 2;
                e.is_mat = 1'b1;
                for (int k = 0; k < NX; k++) e.x[k*W +: W] = to_elem(m_slot[k]);
                for (int s = 0; s < S; s++) e.y[s*W +: W] = to_elem(m_slot[NX + s]);
                exp_q.push_back(e);
            end else if (code == 11) begin
                for (int k = 0; k < NE; k++) m_slot[k] = 0;
                m_idx   = 0;
                m_state = 0;
                model_clear_acc();
            end
        end
    endtask

    // Optional bounce on a different code first, then a stable hold and a quiet release.
    task automatic press(input int code, input int hold_extra, input bit bounce);
        model_key(code);
        if (bounce) begin
            key_code    = 4'((code + 1 + $urandom_range(0, 14)) % 16);
            key_pressed = 1'b1;
            repeat ($urandom_range(1, D - 1)) @(negedge clock);
        end
        key_code    = 4'(code);
        key_pressed = 1'b1;
        repeat (D + hold_extra) @(negedge clock);
        key_pressed = 1'b0;
        repeat (D + $urandom_range(0, 2)) @(negedge clock);
        check("entry_value", entry_value, to_elem(model_entry()));
        check("elem_index", elem_index, m_idx);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!matrix_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("matrix_valid_seen", matrix_valid, 1);
    endtask

    task automatic do_transfer(input int delay);
        repeat (delay) @(negedge clock);
        check("valid_held", matrix_valid, 1);
        for (int k = 0; k < NX; k++) check("x_stable", x_flat[k*W +: W], to_elem(m_slot[k]));
        matrix_ready = 1'b1;
        @(negedge clock);
        matrix_ready = 1'b0;
        m_state      = 0;
        m_idx        = 0;
        check("valid_after_xfer", matrix_valid, 0);
        check("index_after_xfer", elem_index, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, matrix_valid, 0);
        check({tag, "_x"}, x_flat, 0);
        check({tag, "_y"}, y_flat, 0);
        check({tag, "_entry"}, entry_value, 0);
        check({tag, "_index"}, elem_index, 0);
        check({tag, "_error"}, input_error, 0);
    endtask

    // Monitor: pops one expectation per error pulse or per new matrix presentation.
    logic prev_valid = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            if (input_error) begin
                check("error_expected", (exp_q.size() > 0) && !exp_q[0].is_mat, 1);
                if (exp_q.size() > 0 && !exp_q[0].is_mat) void'(exp_q.pop_front());
            end
            if (matrix_valid && !prev_valid) begin
                check("matrix_expected", (exp_q.size() > 0) && exp_q[0].is_mat, 1);
                if (exp_q.size() > 0 && exp_q[0].is_mat) begin
                    check("matrix_x", x_flat, exp_q[0].x);
                    check("matrix_y", y_flat, exp_q[0].y);
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_valid <= matrix_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq[] = '{1, 2, 14, 3, 4, 14, 5, 6, 14, 7, 14, 8, 14, 9, 14, 1, 14, 2, 14, 3, 14, 13};
        int xv[]  = '{12, 34, 56, 7, 8, 9};
        int yv[]  = '{1, 2, 3};
        int guard;
        int r;
        int k;

        reset        = 1'b1;
        key_code     = 4'h0;
        key_pressed  = 1'b0;
        matrix_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (D + 2) @(negedge clock);

        // Reference sequence with known matrix.
        foreach (seq[i]) press(seq[i], 0, 1'b0);
        wait_valid();
        foreach (xv[i]) check("ref_x", x_flat[i*W +: W], to_elem(xv[i]));
        foreach (yv[i]) check("ref_y", y_flat[i*W +: W], to_elem(yv[i]));
        do_transfer(3);

        // Long hold gives one digit; a 2-cycle glitch gives nothing.
        press(5, 1000 - D, 1'b0);
        check("long_hold_entry", entry_value, 5);
        key_code    = 4'h7;
        key_pressed = 1'b1;
        repeat (2) @(negedge clock);
        key_pressed = 1'b0;
        repeat (D + 1) @(negedge clock);
        check("glitch_entry", entry_value, 5);
        press(11, 0, 1'b0);

        // Digit overflow and done in collect each raise one error.
        repeat (4) press(9, 0, 1'b0);
        check("overflow_entry", entry_value, 999);
        press(13, 1, 1'b0);
        check("done_collect_index", elem_index, 0);
        press(11, 0, 1'b0);

        // Sign key, then fill to HOLD and clear.
        press(4, 0, 1'b0);
        press(10, 0, 1'b0);
        press(2, 0, 1'b0);
        press(14, 0, 1'b0);
`ifdef KEYPAD_SIGN_EN
        check("signed_elem0", x_flat[W-1:0], 14'h3FD6);
`else
        check("unsigned_elem0", x_flat[W-1:0], 14'd42);
`endif
        for (int i = 1; i < NE; i++) begin
            press(i, 0, 1'b0);
            press(14, 0, 1'b0);
        end
        press(5, 0, 1'b0);
        check("hold_index", elem_index, NE);
        press(11, 0, 1'b0);
        check("hold_clear_index", elem_index, 0);
        check("hold_clear_x", x_flat, 0);
        check("hold_clear_y", y_flat, 0);

        // Randomized matrices.
        for (int round = 0; round < 5; round++) begin
            guard = 0;
            while (m_state == 0 && guard < 120) begin
                r = $urandom_range(0, 99);
                if (r < 62) k = $urandom_range(0, 9);
                else if (r < 80) k = 14;
                else if (r < 85) k = 10;
                else if (r < 89) k = 11;
                else if (r < 93) k = 13;
                else k = ($urandom_range(0, 1) == 0) ? 12 : 15;
                matrix_ready = 1'($urandom_range(0, 1));
                press(k, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
                guard++;
            end
            matrix_ready = 1'b0;
            while (m_state == 0) press(14, 0, 1'b0);
            if ($urandom_range(0, 1) == 1) press(($urandom_range(0, 1) == 0) ? 14 : 10, 0, 1'b0);
            press(13, $urandom_range(0, 2), 1'b0);
            wait_valid();
            if ($urandom_range(0, 1) == 1) press($urandom_range(0, 15), 0, 1'b0);
            do_transfer($urandom_range(0, 5));
        end

        // Reset while presenting discards everything.
        for (int i = 0; i < NE; i++) begin
            press(i + 1, 0, 1'b0);
            press(14, 0, 1'b0);
        end
        press(13, 0, 1'b0);
        wait_valid();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("reset_present");
        model_reset();
        reset = 1'b0;

        // Keys are disarmed right after reset until a quiet run.
        key_code    = 4'h6;
        key_pressed = 1'b1;
        repeat (D + 2) @(negedge clock);
        key_pressed = 1'b0;
        repeat (D + 1) @(negedge clock);
        check("disarmed_entry", entry_value, 0);
        press(3, 0, 1'b0);
        check("rearmed_entry", entry_value, 3);

        repeat (10) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
